apb_master: RTL and testbench

APB initiator that turns a simple valid/ready request into one APB transfer (SETUP then ACCESS) and returns the result on a valid/ready response channel. It sits between the CPU/DMA-side fabric and the peripheral APB segment: the UART, timers and other responders that hold READY=1 and SLVERR=0, as well as future wait-stating slaves. A wait-state timeout converts a hung slave into an error response.

---
 rtl/apb_master_pkg.sv | 20 ++
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master.sv | 167 ++++++++++++++++
 tb/tb_apb_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator and its wait-state timer.
package apb_master_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned STRB_W          = DATA_W / 8;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Counter width able to hold 0..limit; a disabled timeout still needs one bit.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-cycle counter with synchronous clear/load and an expiry flag.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W = timer_width(LIMIT)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      LAST    = (LIMIT == 0) ? 0 : LIMIT - 1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                          count <= '0;
    else if (clr)                         count <= '0;
    else if (load)                        count <= load_val;
    else if (en && (count != CNT_MAX))    count <= count + CNT_W'(1);
  end

  // Flags the last permitted wait cycle; LIMIT of 0 means never expire.
  assign expired_c = (LIMIT != 0) && (count == CNT_W'(LAST));

endmodule

// File: rtl/apb_master.sv
// APB initiator: one valid/ready request becomes one SETUP+ACCESS transfer with a wait-state timeout.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              REQ_WRITE,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [STRB_W-1:0] REQ_STRB,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int unsigned CNT_W = timer_width(TIMEOUT_CYCLES);

  apb_state_e        state, state_nxt;
  logic              req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic [STRB_W-1:0] pstrb_nxt;
  logic              tmr_clr_c, tmr_en_c, tmr_expired_c;
  logic [CNT_W-1:0]  tmr_count;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .clr       (tmr_clr_c),
    .load      (1'b0),
    .load_val  ({CNT_W{1'b0}}),
    .en        (tmr_en_c),
    .count     (tmr_count),
    .expired_c (tmr_expired_c)
  );

  // State and every output are registered; reset drops PSEL/PENABLE/RSP_VALID immediately.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= IDLE;
      REQ_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      state       <= state_nxt;
      REQ_READY   <= req_ready_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      RSP_RDATA   <= rsp_rdata_nxt;
      RSP_ERR     <= rsp_err_nxt;
      RSP_TIMEOUT <= rsp_timeout_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      PSTRB       <= pstrb_nxt;
    end
  end

  // Next-state and next-output logic; APB payload and response fields hold by default.
  always_comb begin
    state_nxt       = state;
    req_ready_nxt   = REQ_READY;
    rsp_valid_nxt   = RSP_VALID;
    rsp_rdata_nxt   = RSP_RDATA;
    rsp_err_nxt     = RSP_ERR;
    rsp_timeout_nxt = RSP_TIMEOUT;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    pstrb_nxt       = PSTRB;
    tmr_clr_c       = 1'b0;
    tmr_en_c        = 1'b0;

    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        if (REQ_VALID && REQ_READY) begin
          state_nxt     = SETUP;
          req_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          paddr_nxt     = REQ_ADDR;
          pwrite_nxt    = REQ_WRITE;
          pwdata_nxt    = REQ_WRITE ? REQ_WDATA : '0;
          pstrb_nxt     = REQ_WRITE ? REQ_STRB  : '0;
          tmr_clr_c     = 1'b1;
        end
      end

      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end

      ACCESS: begin
        tmr_en_c = 1'b1;
        // PREADY takes priority over an expiry landing in the same cycle.
        if (PREADY) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
        end else if (tmr_expired_c) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end
      end

      RESP: begin
        if (RSP_READY) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with a wait-stating APB slave and a word memory model.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int unsigned T  = 8;
  localparam int unsigned AW = 32;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          REQ_VALID = 1'b0, REQ_WRITE = 1'b0, RSP_READY = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [31:0]   REQ_WDATA = '0;
  logic [3:0]    REQ_STRB = '0;
  logic          REQ_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT;
  logic [31:0]   RSP_RDATA;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0]   PRDATA = '0;

  always #5 CLK = ~CLK;

  apb_master #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  typedef struct { logic [31:0] rdata; logic err; logic tmo; int lat; int acc; int hold; } exp_t;
  typedef struct { int waits; logic slverr; } slv_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; } apb_t;

  exp_t        exp_q[$];
  slv_t        slv_q[$];
  apb_t        apb_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic wait_accept(output int acc);
    int budget = 0;
    while (!REQ_READY && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    if (!REQ_READY) begin
      chk("req_ready_wait", 32'(REQ_READY), 32'd1);
      $fatal(1, "request never accepted");
    end
    acc = cyc + 1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  // Expected response comes from the memory model and the slave's planned behaviour.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input int waits, input logic se, input int hold);
    exp_t e;
    slv_t s;
    apb_t a;
    int   idx;
    int   acc;
    logic [31:0] a_idx;
    a_idx    = addr >> 2;
    idx      = int'(a_idx[3:0]);
    s.waits  = waits;
    s.slverr = se;
    a.addr   = addr;
    a.wr     = wr;
    a.wdata  = wr ? wd : 32'h0;
    a.strb   = wr ? st : 4'h0;
    slv_q.push_back(s);
    apb_q.push_back(a);
    e.tmo   = (waits >= int'(T));
    e.err   = e.tmo || se;
    e.rdata = (wr || e.tmo) ? 32'h0 : ref_mem[idx];
    e.lat   = e.tmo ? int'(T) + 1 : waits + 2;
    e.hold  = hold;
    if (wr && !e.err)
      for (int b = 0; b < 4; b++)
        if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    REQ_VALID = 1'b1;
    REQ_ADDR  = addr;
    REQ_WRITE = wr;
    REQ_WDATA = wd;
    REQ_STRB  = st;
    wait_accept(acc);
    e.acc = acc;
    exp_q.push_back(e);
  endtask

  // APB slave: planned wait states per transfer, random PREADY/PSLVERR/PRDATA when not meaningful.
  initial begin : slave
    slv_t cur;
    int   cnt;
    bit   act;
    logic [31:0] p_idx;
    act = 0;
    cnt = 0;
    cur.waits = 0;
    cur.slverr = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESETn || !PSEL) act = 0;
      if (RESETn && PSEL && PENABLE) begin
        if (!act) begin
          if (slv_q.size() == 0) chk("slave_unplanned_xfer", 32'd1, 32'd0);
          else cur = slv_q.pop_front();
          act = 1;
          cnt = 0;
        end
        p_idx = PADDR >> 2;
        if (cnt == cur.waits) begin
          PREADY  = 1'b1;
          PSLVERR = cur.slverr;
          PRDATA  = PWRITE ? $urandom : slv_mem[p_idx[3:0]];
          if (PWRITE && !cur.slverr)
            for (int b = 0; b < 4; b++)
              if (PSTRB[b]) slv_mem[p_idx[3:0]][8*b +: 8] = PWDATA[8*b +: 8];
        end else begin
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom_range(0, 1));
          PRDATA  = $urandom;
        end
        cnt++;
      end else begin
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end
    end
  end

  // Monitor: APB phase/payload checks and response scoreboard; also drives RSP_READY.
  initial begin : monitor
    apb_t a;
    exp_t e;
    bit   in_rsp;
    logic prev_psel;
    int   hold;
    logic [31:0] r_rdata;
    logic r_err, r_tmo;
    in_rsp = 0; prev_psel = 0; hold = 0;
    a.addr = '0; a.wr = 0; a.wdata = '0; a.strb = '0;
    r_rdata = '0; r_err = 0; r_tmo = 0;
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        in_rsp = 0;
        prev_psel = 0;
        continue;
      end
      chk("ready_valid_exclusive", 32'(REQ_READY && RSP_VALID), 32'd0);
      chk("psel_during_resp", 32'(PSEL && RSP_VALID), 32'd0);
      if (PSEL && !PENABLE) begin
        if (apb_q.size() == 0) chk("apb_unexpected_setup", 32'd1, 32'd0);
        else begin
          a = apb_q.pop_front();
          chk("setup_after_idle", 32'(prev_psel), 32'd0);
          chk("paddr", PADDR, a.addr);
          chk("pwrite", 32'(PWRITE), 32'(a.wr));
          chk("pwdata", PWDATA, a.wdata);
          chk("pstrb", 32'(PSTRB), 32'(a.strb));
        end
      end else if (PSEL && PENABLE) begin
        chk("access_after_setup", 32'(prev_psel), 32'd1);
        chk("paddr_stable", PADDR, a.addr);
        chk("pwdata_stable", PWDATA, a.wdata);
        chk("pstrb_stable", 32'(PSTRB), 32'(a.strb));
      end else begin
        chk("penable_without_psel", 32'(PENABLE), 32'd0);
      end
      prev_psel = PSEL;

      if (RSP_VALID && !in_rsp) begin
        in_rsp = 1;
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("rsp_rdata", RSP_RDATA, e.rdata);
          chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
          chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.tmo));
          hold = e.hold;
        end
        r_rdata = RSP_RDATA; r_err = RSP_ERR; r_tmo = RSP_TIMEOUT;
      end else if (RSP_VALID) begin
        chk("rsp_rdata_stable", RSP_RDATA, r_rdata);
        chk("rsp_flags_stable", 32'({RSP_ERR, RSP_TIMEOUT}), 32'({r_err, r_tmo}));
      end
      if (!RSP_VALID) in_rsp = 0;

      if (in_rsp && hold > 0) begin
        RSP_READY = 1'b0;
        hold--;
      end else begin
        RSP_READY = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int budget;
    apb_t a;
    slv_t s;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_req_ready", 32'(REQ_READY), 32'd0);
    chk("reset_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
    chk("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("reset_paddr", PADDR, 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("req_ready_after_reset", 32'(REQ_READY), 32'd1);

    issue(32'h8C, 1'b1, 32'h41, 4'hF, 0, 1'b0, 0);          // UART TX write
    issue(32'h90, 1'b1, 32'h3, 4'hF, 0, 1'b0, 0);           // control write
    issue(32'h90, 1'b0, $urandom, 4'hF, 0, 1'b0, 0);        // control read-back
    issue(32'hA0, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
    issue(32'hA0, 1'b0, 32'h0, 4'h0, 3, 1'b0, 0);           // three wait states
    issue(32'h84, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 0);        // stuck slave
    issue(32'h88, 1'b1, $urandom, 4'h5, int'(T) - 1, 1'b0, 0); // ready on last allowed cycle
    issue(32'h88, 1'b0, 32'h0, 4'h0, int'(T), 1'b0, 0);     // one cycle too late
    issue(32'h94, 1'b0, 32'h0, 4'h0, 0, 1'b1, 5);           // slave error, stalled consumer
    issue(32'h98, 1'b1, $urandom, 4'hF, 1, 1'b1, 2);        // rejected write

    for (int n = 0; n < 150; n++) begin
      int w;
      w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 12));
      issue(32'h80 | (32'($urandom_range(0, 15)) << 2), 1'($urandom_range(0, 1)), $urandom,
            4'($urandom_range(0, 15)), w, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge CLK);
      budget++;
    end
    chk("drain_responses", 32'(exp_q.size()), 32'd0);

    // Reset asserted in the middle of a long ACCESS phase.
    s.waits = 1000; s.slverr = 1'b0;
    a.addr = 32'hB0; a.wr = 1'b0; a.wdata = '0; a.strb = '0;
    slv_q.push_back(s);
    apb_q.push_back(a);
    REQ_VALID = 1'b1; REQ_ADDR = 32'hB0; REQ_WRITE = 1'b0;
    wait_accept(acc);
    budget = 0;
    while (!(PSEL && PENABLE) && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    chk("reached_access", 32'(PSEL && PENABLE), 32'd1);
    repeat (2) @(negedge CLK);
    #2 RESETn = 1'b0;
    #1;
    chk("async_reset_psel", 32'({PSEL, PENABLE}), 32'd0);
    chk("async_reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("req_ready_after_midreset", 32'(REQ_READY), 32'd1);
    repeat (12) @(negedge CLK);
    chk("no_rsp_after_midreset", 32'(RSP_VALID), 32'd0);
    chk("slave_queue_empty", 32'(slv_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
